// File: rtl/hid_uart_pkg.sv
// hid_uart_pkg: shared frame constants, FSM state encoding and ASCII helpers
//   FRAME_LEN   characters per report line (type, ':', 16 hex, CR, LF)
//   CH_*        ASCII codes used in a frame
//   state_e     frame FSM states
//   hex_ascii   nibble -> uppercase hex character
//   type_ascii  usb_type -> type character
package hid_uart_pkg;
  localparam int FRAME_LEN = 20;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_NONE  = 8'h2D;
  localparam logic [7:0] CH_KBD   = 8'h4B;
  localparam logic [7:0] CH_MOUSE = 8'h4D;
  localparam logic [7:0] CH_PAD   = 8'h47;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SEND, ST_NEXT} state_e;
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? {4'h3, n} : 8'h37 + {4'h0, n};
  endfunction
  function automatic logic [7:0] type_ascii(input logic [1:0] t);
    return (t == 2'd0) ? CH_NONE : (t == 2'd1) ? CH_KBD : (t == 2'd2) ? CH_MOUSE : CH_PAD;
  endfunction
endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 byte transmitter with baud and bit counters
//   clk, resetn  clock, async active-low reset
//   start, data  load and begin sending data (accepted even during the stop bit)
//   done         pulse three clocks before the stop bit ends so the caller can
//                queue the next byte with no idle gap
//   tx           serial line, high when idle or in reset
//   active       a character is on the line
module uart_tx_byte #(
  parameter int DIV = 104
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [7:0] data,
  output logic       done,
  output logic       tx,
  output logic       active
);
  localparam int BW = $clog2(DIV);
  logic [BW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;
  logic [9:0]    sh_q, sh_d;
  logic          act_q, act_d;
  always_comb begin
    baud_d = baud_q;
    bit_d  = bit_q;
    sh_d   = sh_q;
    act_d  = act_q;
    if (start) begin
      baud_d = '0;
      bit_d  = '0;
      sh_d   = {1'b1, data, 1'b0};
      act_d  = 1'b1;
    end else if (act_q) begin
      if (baud_q == BW'(DIV - 1)) begin
        baud_d = '0;
        sh_d   = {1'b1, sh_q[9:1]};
        bit_d  = (bit_q == 4'd9) ? 4'd0 : bit_q + 4'd1;
        act_d  = bit_q != 4'd9;
      end else begin
        baud_d = baud_q + 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      baud_q <= '0;
      bit_q  <= '0;
      sh_q   <= '1;
      act_q  <= 1'b0;
    end else begin
      baud_q <= baud_d;
      bit_q  <= bit_d;
      sh_q   <= sh_d;
      act_q  <= act_d;
    end
  end
  // Early done covers NEXT and LOAD so the following start bit lands right after this stop bit.
  assign done   = act_q && bit_q == 4'd9 && baud_q == BW'(DIV - 3);
  assign tx     = !act_q || sh_q[0];
  assign active = act_q;
endmodule

// File: rtl/hid_report_uart.sv
// hid_report_uart: prints each HID report as an ASCII line over an 8N1 UART
//   clk, resetn               clock, async active-low reset
//   report_stb                one-cycle strobe qualifying report_data/usb_type
//   report_data, usb_type     report bytes (byte 0 in [7:0]) and device type
//   uart_tx                   serial output
//   busy                      frame in flight or report pending
//   drop_cnt                  reports lost to overwrite, saturating
module hid_report_uart
  import hid_uart_pkg::*;
#(
  parameter int CLK_HZ = 12000000,
  parameter int BAUD   = 115200,
  parameter int DIV    = (CLK_HZ + BAUD / 2) / BAUD
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        report_stb,
  input  logic [63:0] report_data,
  input  logic [1:0]  usb_type,
  output logic        uart_tx,
  output logic        busy,
  output logic [7:0]  drop_cnt
);
  state_e      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic        pend_vld_q, pend_vld_d;
  logic [63:0] pend_data_q, pend_data_d;
  logic [1:0]  pend_type_q, pend_type_d;
  logic [63:0] work_q, work_d;
  logic [7:0]  drop_q, drop_d;
  logic        consume, tx_start, tx_done, tx_active;
  logic [3:0]  hex_idx, nib;
  logic [7:0]  ch;
  // The first LOAD of a frame moves the pending report into the working copy;
  // the type char is taken straight from the pending register in that cycle.
  assign consume  = state_q == ST_LOAD && idx_q == 5'd0;
  assign tx_start = state_q == ST_LOAD;
  assign hex_idx  = 4'(idx_q - 5'd2);
  assign nib      = work_q[{hex_idx[3:1], ~hex_idx[0], 2'b00} +: 4];
  assign ch = (idx_q == 5'd0) ? type_ascii(pend_type_q) :
              (idx_q == 5'd1) ? CH_COLON :
              (idx_q == 5'(FRAME_LEN - 2)) ? CH_CR :
              (idx_q == 5'(FRAME_LEN - 1)) ? CH_LF : hex_ascii(nib);
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: if (pend_vld_q || report_stb) begin
        state_d = ST_LOAD;
        idx_d   = '0;
      end
      ST_LOAD: state_d = ST_SEND;
      ST_SEND: if (tx_done) state_d = ST_NEXT;
      ST_NEXT: if (idx_q != 5'(FRAME_LEN - 1)) begin
        idx_d   = idx_q + 5'd1;
        state_d = ST_LOAD;
      end else if (pend_vld_q) begin
        idx_d   = '0;
        state_d = ST_LOAD;
      end else if (!tx_active) begin
        // Hold until the LF stop bit has left the line so busy covers it.
        idx_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_comb begin
    pend_vld_d  = pend_vld_q && !consume;
    pend_data_d = pend_data_q;
    pend_type_d = pend_type_q;
    work_d      = consume ? pend_data_q : work_q;
    drop_d      = drop_q;
    if (report_stb) begin
      pend_vld_d  = 1'b1;
      pend_data_d = report_data;
      pend_type_d = usb_type;
      if (pend_vld_q && !consume && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      pend_vld_q  <= 1'b0;
      pend_data_q <= '0;
      pend_type_q <= '0;
      work_q      <= '0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pend_vld_q  <= pend_vld_d;
      pend_data_q <= pend_data_d;
      pend_type_q <= pend_type_d;
      work_q      <= work_d;
      drop_q      <= drop_d;
    end
  end
  uart_tx_byte #(.DIV(DIV)) u_tx (
    .clk    (clk),
    .resetn (resetn),
    .start  (tx_start),
    .data   (ch),
    .done   (tx_done),
    .tx     (uart_tx),
    .active (tx_active)
  );
  assign busy     = !(state_q == ST_IDLE && !pend_vld_q);
  assign drop_cnt = drop_q;
endmodule

// File: tb/tb_hid_report_uart.sv
// tb_hid_report_uart: directed checks of frame content, timing, drops and reset
module tb_hid_report_uart;
  localparam int DIV = 16;
  localparam int CHR = 10 * DIV;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        report_stb = 1'b0;
  logic [63:0] report_data = '0;
  logic [1:0]  usb_type = '0;
  logic        uart_tx, busy;
  logic [7:0]  drop_cnt;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [7:0]  rx_q[$];
  int          rx_t[$];
  hid_report_uart #(.CLK_HZ(1843200), .BAUD(115200)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .report_stb  (report_stb),
    .report_data (report_data),
    .usb_type    (usb_type),
    .uart_tx     (uart_tx),
    .busy        (busy),
    .drop_cnt    (drop_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // UART receiver: samples mid-bit, stamps the cycle the start bit is first seen,
  // and discards any character that overlapped a reset.
  initial begin : rx
    logic [7:0] c;
    logic       bad, stop;
    int         t0;
    forever begin
      @(negedge clk);
      if (resetn === 1'b1 && uart_tx === 1'b0) begin
        t0  = cyc;
        bad = 1'b0;
        c   = '0;
        repeat (DIV / 2) begin @(negedge clk); bad |= !resetn; end
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) begin @(negedge clk); bad |= !resetn; end
          c[i] = uart_tx;
        end
        repeat (DIV) begin @(negedge clk); bad |= !resetn; end
        stop = uart_tx;
        if (!bad) begin
          check("stop_bit", 160'(stop), 160'(1));
          rx_q.push_back(c);
          rx_t.push_back(t0);
        end
      end
    end
  end
  task automatic strobe(input logic [1:0] t, input logic [63:0] d);
    report_stb  = 1'b1;
    usb_type    = t;
    report_data = d;
    @(negedge clk);
    report_stb  = 1'b0;
  endtask
  task automatic get_frame(input string tag, input logic [159:0] exp, output int t0, output int tl);
    logic [159:0] f;
    int k;
    f = '0; k = 0; t0 = cyc; tl = cyc;
    while (rx_q.size() < 20 && k < 40 * CHR) begin @(negedge clk); k++; end
    if (rx_q.size() < 20) begin
      check({tag, "_timeout"}, 160'(rx_q.size()), 160'(20));
    end else begin
      t0 = rx_t[0];
      tl = rx_t[19];
      check({tag, "_span"}, 160'(tl - t0), 160'(19 * CHR));
      for (int i = 0; i < 20; i++) begin
        f = {f[151:0], rx_q.pop_front()};
        void'(rx_t.pop_front());
      end
      check(tag, f, exp);
    end
  endtask
  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy === 1'b1 && k < 50 * CHR) begin @(negedge clk); k++; end
    check(tag, 160'(busy), 160'(0));
  endtask
  initial begin
    int t_s, t_a, t_b, tl, lows, target, k;
    repeat (5) @(negedge clk);
    check("rst_tx", 160'(uart_tx), 160'(1));
    check("rst_busy", 160'(busy), 160'(0));
    check("rst_drop", 160'(drop_cnt), 160'(0));
    resetn = 1'b1;
    repeat (3 * CHR) @(negedge clk);
    check("release_no_frame", 160'(rx_q.size()), 160'(0));
    check("release_busy", 160'(busy), 160'(0));
    // keyboard report
    t_s = cyc;
    strobe(2'd1, 64'h0000_0000_0004_0000);
    check("busy_on_accept", 160'(busy), 160'(1));
    get_frame("kbd", "K:0000040000000000\r\n", t_a, tl);
    check("latency_le2", 160'((t_a - t_s) <= 2), 160'(1));
    wait_idle("kbd_idle");
    check("kbd_drop", 160'(drop_cnt), 160'(0));
    // three strobes: S2 overwritten by S3
    strobe(2'd2, 64'h0123_4567_89AB_CDEF);
    repeat (500) @(negedge clk);
    strobe(2'd3, 64'h1111_2222_3333_4444);
    repeat (300) @(negedge clk);
    strobe(2'd1, 64'hFEDC_BA98_7654_3210);
    get_frame("s1", "M:EFCDAB8967452301\r\n", t_a, tl);
    get_frame("s3", "K:1032547698BADCFE\r\n", t_b, tl);
    check("back_to_back", 160'(t_b - t_a), 160'(20 * CHR));
    check("drop_one", 160'(drop_cnt), 160'(1));
    check("busy_in_lf_stop", 160'(busy), 160'(1));
    wait_idle("s3_idle");
    check("busy_fall_after_lf", 160'(cyc >= tl + CHR), 160'(1));
    // strobe in the cycle the pending report is consumed
    strobe(2'd0, 64'h1122_3344_5566_7788);
    repeat (200) @(negedge clk);
    strobe(2'd3, 64'h0000_0000_0000_00A5);
    get_frame("c1", "-:8877665544332211\r\n", t_a, tl);
    target = tl + CHR - 1;
    while (cyc < target) @(negedge clk);
    strobe(2'd2, 64'h8000_0000_0000_0000);
    get_frame("c2", "G:A500000000000000\r\n", t_a, tl);
    get_frame("c3", "M:0000000000000080\r\n", t_b, tl);
    check("c_drop_same", 160'(drop_cnt), 160'(1));
    wait_idle("c_idle");
    // 300 overwriting strobes during one frame
    strobe(2'd1, 64'h0);
    repeat (10) @(negedge clk);
    for (int i = 0; i < 300; i++) strobe(2'd2, 64'(i));
    check("drop_sat", 160'(drop_cnt), 160'(255));
    get_frame("sat_f1", "K:0000000000000000\r\n", t_a, tl);
    get_frame("sat_f2", "M:2B01000000000000\r\n", t_b, tl);
    wait_idle("sat_idle");
    check("drop_sat_hold", 160'(drop_cnt), 160'(255));
    // reset during character 7, bit 3 (a '0', so the line is low there)
    strobe(2'd1, 64'h5A);
    k = 0;
    while (rx_t.size() < 1 && k < 4 * CHR) begin @(negedge clk); k++; end
    if (rx_t.size() > 0) t_s = rx_t[0];
    else begin
      check("rst_first_char", 160'(rx_t.size()), 160'(1));
      t_s = cyc;
    end
    target = t_s + 7 * CHR + 4 * DIV + DIV / 2;
    while (cyc < target) @(negedge clk);
    check("tx_before_reset", 160'(uart_tx), 160'(0));
    #2 resetn = 1'b0;
    #1;
    check("rst_mid_tx", 160'(uart_tx), 160'(1));
    check("rst_mid_busy", 160'(busy), 160'(0));
    check("rst_mid_drop", 160'(drop_cnt), 160'(0));
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    rx_q.delete();
    rx_t.delete();
    lows = 0;
    repeat (3 * CHR) begin @(negedge clk); lows += (uart_tx === 1'b1) ? 0 : 1; end
    check("rst_no_resume", 160'(lows), 160'(0));
    check("rst_no_chars", 160'(rx_q.size()), 160'(0));
    check("rst_busy_after", 160'(busy), 160'(0));
    // type none, all ones
    strobe(2'd0, '1);
    get_frame("ones", "-:FFFFFFFFFFFFFFFF\r\n", t_a, tl);
    wait_idle("ones_idle");
    check("ones_drop", 160'(drop_cnt), 160'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hid_report_uart.md
HID_REPORT_UART -- requirements
Module: hid_report_uart

Interface
REQ-001 Parameter CLK_HZ, default 12000000, frequency of clk in Hz.
REQ-002 Parameter BAUD, default 115200, UART bit rate.
REQ-003 Parameter DIV, default CLK_HZ/BAUD rounded to nearest (104), clocks per UART bit; SHALL be at least 4.
REQ-004 clk  input  1  sole clock; all state on its rising edge.
REQ-005 resetn  input  1  reset, asynchronous assert, active-low.
REQ-006 report_stb  input  1  single-cycle strobe; report_data and usb_type valid in that cycle.
REQ-007 report_data  input  64  HID report; byte 0 in bits [7:0].
REQ-008 usb_type  input  2  0 none, 1 keyboard, 2 mouse, 3 gamepad.
REQ-009 uart_tx  output  1  8N1 serial output; idle high.
REQ-010 busy  output  1  high while a frame is being transmitted or one is pending.
REQ-011 drop_cnt  output  8  count of reports lost to overwrite; saturates at 255.

Function
REQ-012 Each accepted report SHALL produce one 20-character ASCII frame: type char, ':', 16 hex digits, CR (0x0D), LF (0x0A).
REQ-013 Type char SHALL be '-' (0x2D), 'K', 'M', 'G' for usb_type 0..3; usb_type SHALL be latched with the data.
REQ-014 Hex digits SHALL be uppercase, in byte order 0..7, high nibble before low nibble within each byte (byte 0x5A -> "5A").
REQ-015 Each character SHALL be sent as start bit 0, 8 data bits LSB first, stop bit 1; every bit lasts exactly DIV clocks; characters SHALL be back-to-back with no idle gap.
REQ-016 Frame FSM states: IDLE, LOAD, SEND, NEXT. IDLE->LOAD on a held or pending report. LOAD latches the character. LOAD->SEND. SEND->NEXT when the byte transmitter finishes. NEXT->LOAD while the index is below 19. NEXT->IDLE or LOAD after index 19, depending on whether a report is pending.
REQ-017 Latency: with report_stb asserted in IDLE at cycle N, the start bit SHALL appear on uart_tx at cycle N+2 at the latest.
REQ-018 Capture: a single pending register (data and type) holds reports. It SHALL capture report_stb in any state. The frame being sent uses its own working copy, which is never modified mid-frame.
REQ-019 If report_stb arrives while the pending register is already full, it SHALL overwrite the register (latest wins) and drop_cnt SHALL increment, saturating at 255.
REQ-020 If report_stb coincides with the cycle the FSM moves the pending register to the working copy, the new report SHALL become pending and SHALL NOT be counted as dropped.
REQ-021 The next frame SHALL start in the cycle after the current frame's LF stop bit ends, taking its content from the pending register.
REQ-022 busy SHALL be low exactly when the FSM is in IDLE and nothing is pending.
REQ-023 Baud counter width SHALL be clog2(DIV); bit counter SHALL be 4 bits; character index SHALL be 5 bits.

Reset
REQ-024 When resetn is low: uart_tx=1, busy=0, drop_cnt=0, FSM=IDLE, pending register empty, all counters 0.
REQ-025 Reset asserted mid-character SHALL take uart_tx high immediately (asynchronously); after reset release, no partial frame SHALL resume.
REQ-026 Release of resetn SHALL NOT itself start a frame.

Structure
REQ-027 A shared package/include hid_uart_pkg SHALL hold: the frame length (20), the ASCII constants (CR, LF, ':', type chars), and the FSM state encodings.
REQ-028 A sub-module uart_tx_byte SHALL contain the baud and bit counters. Its interface: byte in, start strobe in, done pulse out, tx out.
REQ-029 Nibble-to-ASCII conversion SHALL be a function declared in hid_uart_pkg.

Verification
REQ-030 Keyboard report: usb_type=1, data=64'h0000_0000_0004_0000 (byte 2 = 0x04). Required: decoded line "K:0000040000000000\r\n"; every bit lasts 104 clocks.
REQ-031 Three strobes in quick succession: S1 while idle, S2 and S3 during frame 1. Required: frames S1 then S3; drop_cnt=1; busy falls after frame 2's LF.
REQ-032 A strobe in the same cycle the pending report is consumed. Required: two frames follow, drop_cnt unchanged.
REQ-033 300 overwriting strobes during one frame. Required: drop_cnt=255.
REQ-034 resetn pulsed low at character 7, bit 3. Required: uart_tx=1 within that cycle, busy=0, no output after release until the next strobe.
REQ-035 usb_type=0 with data all ones. Required: "-:FFFFFFFFFFFFFFFF\r\n".
